// File: rtl/lod4_arb_pkg.sv
// rtl/lod4_arb_pkg.sv - shared types and sizes for the lod4 round-robin arbiter
package lod4_arb_pkg;

  localparam int N_REQ = 4;
  localparam int ID_W  = 2;

  typedef logic [ID_W-1:0] req_id_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/lod4_arbiter_if.sv
// rtl/lod4_arbiter_if.sv - request/grant bundle between requesters (master) and arbiter (slave)
interface lod4_arbiter_if;
  import lod4_arb_pkg::*;

  logic             rx_enable;
  logic [N_REQ-1:0] rx_req;
  logic [N_REQ-1:0] tx_grant;
  req_id_t          tx_grant_id;
  logic             tx_grant_valid;
  logic             tx_timeout;

  modport master (
    output rx_enable, rx_req,
    input  tx_grant, tx_grant_id, tx_grant_valid, tx_timeout
  );

  modport slave (
    input  rx_enable, rx_req,
    output tx_grant, tx_grant_id, tx_grant_valid, tx_timeout
  );

endinterface

// File: rtl/lod4.sv
// rtl/lod4.sv - 4-bit leading-one detector: index of the highest set bit, gated by en_i
module lod4
  import lod4_arb_pkg::*;
(
  input  logic             en_i,
  input  logic [N_REQ-1:0] vec_i,
  output req_id_t          idx_o,
  output logic             valid_o
);

  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    if (en_i) begin
      valid_o = |vec_i;
      casez (vec_i)
        4'b1???: idx_o = 2'd3;
        4'b01??: idx_o = 2'd2;
        4'b001?: idx_o = 2'd1;
        default: idx_o = 2'd0;
      endcase
    end
  end

endmodule

// File: rtl/lod4_arbiter.sv
// rtl/lod4_arbiter.sv - 4-way round-robin arbiter built on lod4 picks
// LOD4_ARBITER_TIMEOUT_EN adds a HOLD_MAX forced release with a tx_timeout pulse.
module lod4_arbiter
  import lod4_arb_pkg::*;
#(
  parameter int HOLD_MAX = 16,
  parameter int CNT_W    = $clog2(HOLD_MAX + 1)
) (
  input  logic           aclk,
  input  logic           aresetn,
  lod4_arbiter_if.slave  bus
);

  arb_state_t       state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  req_id_t          id_q, id_d;
  logic             valid_q, valid_d;
  req_id_t          last_id_q, last_id_d;

  logic [N_REQ-1:0] mask;
  logic             lod_en;
  req_id_t          m_idx, u_idx, pick;
  logic             m_valid, u_valid;

  // Prefer requesters strictly below the last holder, then wrap to the top.
  assign mask   = (N_REQ'(1) << last_id_q) - N_REQ'(1);
  assign lod_en = (state_q == IDLE) && bus.rx_enable;

  lod4 u_lod_masked (
    .en_i    (lod_en),
    .vec_i   (bus.rx_req & mask),
    .idx_o   (m_idx),
    .valid_o (m_valid)
  );

  lod4 u_lod_full (
    .en_i    (lod_en),
    .vec_i   (bus.rx_req),
    .idx_o   (u_idx),
    .valid_o (u_valid)
  );

  assign pick = m_valid ? m_idx : u_idx;

`ifdef LOD4_ARBITER_TIMEOUT_EN
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             timeout_q, timeout_d;
`else
  localparam int unused_hold_cfg = HOLD_MAX + CNT_W;
`endif

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    id_d      = id_q;
    valid_d   = valid_q;
    last_id_d = last_id_q;
`ifdef LOD4_ARBITER_TIMEOUT_EN
    hold_cnt_d = hold_cnt_q;
    timeout_d  = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (u_valid) begin
          state_d   = GRANT;
          grant_d   = N_REQ'(1) << pick;
          id_d      = pick;
          valid_d   = 1'b1;
          last_id_d = pick;
`ifdef LOD4_ARBITER_TIMEOUT_EN
          hold_cnt_d = CNT_W'(1);
`endif
        end else begin
          grant_d = '0;
          id_d    = '0;
          valid_d = 1'b0;
        end
      end
      GRANT: begin
        if (!bus.rx_req[id_q]) begin
          state_d = RELEASE;
          grant_d = '0;
          id_d    = '0;
          valid_d = 1'b0;
        end
`ifdef LOD4_ARBITER_TIMEOUT_EN
        else if (hold_cnt_q == CNT_W'(HOLD_MAX)) begin
          state_d   = RELEASE;
          grant_d   = '0;
          id_d      = '0;
          valid_d   = 1'b0;
          timeout_d = 1'b1;
        end else if (hold_cnt_q != {CNT_W{1'b1}}) begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
`endif
      end
      RELEASE: begin
        state_d = IDLE;
        grant_d = '0;
        id_d    = '0;
        valid_d = 1'b0;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        id_d    = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      id_q      <= '0;
      valid_q   <= 1'b0;
      last_id_q <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      id_q      <= id_d;
      valid_q   <= valid_d;
      last_id_q <= last_id_d;
    end
  end

`ifdef LOD4_ARBITER_TIMEOUT_EN
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign bus.tx_timeout = timeout_q;
`else
  assign bus.tx_timeout = 1'b0;
`endif

  assign bus.tx_grant       = grant_q;
  assign bus.tx_grant_id    = id_q;
  assign bus.tx_grant_valid = valid_q;

endmodule

// File: tb/tb_lod4_arbiter.sv
// tb/tb_lod4_arbiter.sv - directed bench for lod4_arbiter; observed word is {grant, id, valid, timeout}
module tb_lod4_arbiter;

  logic aclk;
  logic aresetn;
  int   n_tests;
  int   n_fail;

  lod4_arbiter_if bus ();

  lod4_arbiter #(.HOLD_MAX(4)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  localparam logic [7:0] IDLE_W = 8'h00;

  function automatic logic [7:0] granted(input int id);
    logic [3:0] g;
    g = 4'b0001 << id;
    return {g, 2'(id), 1'b1, 1'b0};
  endfunction

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] exp);
    logic [7:0] obs;
    obs = {bus.tx_grant, bus.tx_grant_id, bus.tx_grant_valid, bus.tx_timeout};
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  int exp_ids [5] = '{3, 2, 1, 0, 3};

  initial begin
    n_tests       = 0;
    n_fail        = 0;
    aresetn       = 1'b0;
    bus.rx_enable = 1'b0;
    bus.rx_req    = 4'b1111;
    step();
    step();
    chk("reset_outputs", IDLE_W);

    // leave reset with everyone requesting: pure leading one wins
    aresetn       = 1'b1;
    bus.rx_enable = 1'b1;
    step();
    chk("first_grant", granted(3));

    // rotation: each holder keeps 3 cycles, drops for one, reasserts
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rr_hold2", granted(exp_ids[i]));
      step();
      chk("rr_hold3", granted(exp_ids[i]));
      bus.rx_req = 4'b1111 & ~(4'b0001 << exp_ids[i]);
      step();
      chk("rr_release", IDLE_W);
      bus.rx_req = 4'b1111;
      step();
      chk("rr_dead", IDLE_W);
      step();
      chk("rr_next", granted(exp_ids[i+1]));
    end

    // make requester 1 the last holder
    bus.rx_req = 4'b0000;
    step();
    chk("drop_all", IDLE_W);
    step();
    bus.rx_req = 4'b0010;
    step();
    chk("set_last1", granted(1));

    // masked vector empty -> wrap to leading one
    bus.rx_req = 4'b1100;
    step();
    step();
    step();
    chk("wrap_to3", granted(3));

    bus.rx_req = 4'b0101;
    step();
    step();
    step();
    chk("below3_is2", granted(2));

    // enable gating
    bus.rx_req    = 4'b0000;
    bus.rx_enable = 1'b0;
    step();
    step();
    bus.rx_req = 4'b0010;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("gated", IDLE_W);
    end
    bus.rx_enable = 1'b1;
    step();
    chk("enable_grant", granted(1));
    bus.rx_enable = 1'b0;
    step();
    chk("en_low_hold1", granted(1));
    step();
    chk("en_low_hold2", granted(1));

    // long hold by requester 0
    bus.rx_enable = 1'b1;
    bus.rx_req    = 4'b0000;
    step();
    step();
    bus.rx_req = 4'b0001;
    step();
    chk("hold_start", granted(0));
`ifdef LOD4_ARBITER_TIMEOUT_EN
    step();
    chk("to_cnt2", granted(0));
    step();
    chk("to_cnt3", granted(0));
    step();
    chk("to_cnt4", granted(0));
    step();
    chk("to_pulse", 8'b0000_00_0_1);
    step();
    chk("to_dead", IDLE_W);
    step();
    chk("to_regrant", granted(0));
`else
    for (int i = 0; i < 110; i++) begin
      step();
      chk("no_timeout_hold", granted(0));
    end
`endif

    // holder 2 then asynchronous reset between edges
    bus.rx_req = 4'b0000;
    step();
    step();
    bus.rx_req = 4'b0100;
    step();
    chk("pre_rst_grant", granted(2));
    bus.rx_req = 4'b0110;
    #2;
    aresetn = 1'b0;
    #1;
    chk("async_rst", IDLE_W);
    #1;
    aresetn = 1'b1;
    step();
    chk("post_rst_pick", granted(2));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lod4_arbiter.md
Name: lod4_arbiter

Overview:
- Four-requester arbiter that shares one downstream resource with rotating (round-robin) priority.
- Each pick is the leading one of a masked request vector, computed by an instantiated lod4.
- The grant is held while the holder keeps requesting. An optional timeout forces release.
- Sits in front of any single-ported datapath resource in the lod4 family.

Parameters:
- HOLD_MAX, 16, maximum consecutive grant cycles before forced release. Range 2..65535; used only when the timeout feature is compiled in.
- CNT_W, $clog2(HOLD_MAX+1), width of the hold counter.

Ports:
- aclk  input  1  clock; all state updates on the rising edge.
- aresetn  input  1  asynchronous, active-low reset.
- rx_enable  input  1  arbitration enable; low blocks new grants only.
- rx_req  input  4  request vector, one bit per requester; level-sensitive.
- tx_grant  output  4  one-hot grant, registered; all zero when no grant.
- tx_grant_id  output  2  index of the current holder; valid only while tx_grant_valid.
- tx_grant_valid  output  1  high while a grant is held.
- tx_timeout  output  1  one-cycle pulse on forced release.

Behaviour:
- Reset: one clock (aclk); reset is asynchronous and active-low (aresetn). Reset values:
  - state=IDLE
  - tx_grant=4'b0000, tx_grant_id=2'b00, tx_grant_valid=0, tx_timeout=0
  - last_id=2'b00, hold_cnt=0
- Deassertion of aresetn takes effect at the next aclk edge.
- States: IDLE, GRANT, RELEASE (enum in package).
- Priority mask: mask = bits strictly below last_id, i.e. (4'b1 << last_id) - 1.
  - If (rx_req & mask) is nonzero, pick its leading one (highest index).
  - Otherwise pick the leading one of rx_req.
  - The pick is combinational via two lod4 instances, or one lod4 plus a mux.
  - The lod4 enable is tied to (state==IDLE && rx_enable).
- IDLE:
  - If rx_enable=1 and rx_req!=0: next state GRANT.
  - Set tx_grant=1<<pick, tx_grant_id=pick, tx_grant_valid=1, last_id=pick, hold_cnt=1.
  - Latency is 1 cycle from request visible in IDLE to grant.
  - Otherwise remain in IDLE with outputs zero.
- GRANT:
  - If rx_req[tx_grant_id]=0: go to RELEASE and clear grant outputs the same edge.
  - Else, with timeout enabled and hold_cnt==HOLD_MAX: go to RELEASE, clear grant outputs, pulse tx_timeout for 1 cycle.
  - Else hold_cnt++ (saturating).
  - rx_enable going low does not revoke a held grant.
  - Requests from other requesters are ignored while in GRANT.
- RELEASE: exactly one dead cycle, outputs zero, then IDLE. Minimum gap between grants is therefore 2 cycles.
- Simultaneous events: holder drop and timeout on the same cycle are treated as a normal release; tx_timeout stays 0.
- Round-robin: after holder k, the next pick prefers indices k-1 down to 0, then wraps to 3 down to k.
  - A sole requester may be regranted immediately after its own release.
- Reset mid-grant: grant drops asynchronously; last_id returns to 0, so the first post-reset pick is pure leading-one.
- Invariant: tx_grant is always zero or one-hot and equals 1<<tx_grant_id when valid.

Optional Feature:
- Macro: LOD4_ARBITER_TIMEOUT_EN.
- Defined: the HOLD_MAX forced release above applies, and tx_timeout pulses on forced release.
- Undefined: no forced release; the grant is held indefinitely while rx_req[id]=1. tx_timeout is tied 0. hold_cnt logic is omitted.

Decomposition:
- Package lod4_arb_pkg holds:
  - typedef enum logic [1:0] {IDLE, GRANT, RELEASE} arb_state_t
  - localparam N_REQ=4, ID_W=2
  - typedef logic [ID_W-1:0] req_id_t
- Sub-module: the existing lod4 leading-one detector, instantiated for masked and unmasked picks. No other sub-modules.

Test Plan:
- Reset behaviour: aresetn=0 with rx_req=4'b1111 -> all outputs 0. Release reset, rx_enable=1 -> next edge tx_grant=4'b1000, id=3.
- Round-robin rotation: rx_req=4'b1111 held, each holder drops its bit for 1 cycle after 3 cycles of grant, then reasserts -> grant order 3,2,1,0,3.
- Leading-one with wrap: last_id=1, rx_req=4'b1100 -> masked vector empty, grant id=3. Then last_id=3, rx_req=4'b0101 -> grant id=2.
- Enable gating: rx_enable=0, rx_req=4'b0010 -> no grant for 10 cycles. Enable rises -> grant id=1 one cycle later. Drop rx_enable mid-grant -> grant persists.
- Timeout (macro defined, HOLD_MAX=4): rx_req=4'b0001 held -> tx_grant_valid high exactly 4 cycles, tx_timeout pulse, 1 RELEASE cycle, regrant id=0. Macro undefined -> grant held 100+ cycles, tx_timeout=0.
- Async reset mid-grant: assert aresetn=0 between edges during GRANT -> tx_grant=0 immediately without waiting for aclk. After release, pick ignores the old last_id.
